// File: rtl/time_set_ctrl_if.sv
// Datapath bus between the time-set controller and the clock datapath.
// master: controller side, which reads the current BCD digits and drives the
//         load enable, the digit selector and the value to load.
// slave:  datapath side.
//   cur_h1..cur_s2  4b each  current BCD digits (h1 = tens of hours ... s2 = units of seconds)
//   load            1b       load enable
//   select          3b       digit selector: 5=h1, 4=h2, 3=m1, 2=m2, 1=s1, 0=s2
//   loadin          4b       BCD value to load into the selected digit
interface time_set_ctrl_if;
  localparam int unsigned DIG_W = 4;
  localparam int unsigned IDX_W = 3;

  logic [DIG_W-1:0] cur_h1;
  logic [DIG_W-1:0] cur_h2;
  logic [DIG_W-1:0] cur_m1;
  logic [DIG_W-1:0] cur_m2;
  logic [DIG_W-1:0] cur_s1;
  logic [DIG_W-1:0] cur_s2;
  logic             load;
  logic [IDX_W-1:0] select;
  logic [DIG_W-1:0] loadin;

  modport master (
    input  cur_h1, cur_h2, cur_m1, cur_m2, cur_s1, cur_s2,
    output load, select, loadin
  );

  modport slave (
    output cur_h1, cur_h2, cur_m1, cur_m2, cur_s1, cur_s2,
    input  load, select, loadin
  );
endinterface

// File: rtl/time_set_ctrl.sv
// Time-set controller: steps through the six clock digits with the mode
// button, adjusts the selected digit with inc/dec (wrapping within the
// digit's legal range), writes each value straight into the datapath while
// editing, and auto-exits after TIMEOUT quiet cycles.
// Ports:
//   clk_out    in   clock, all state changes on the rising edge
//   rst_n      in   asynchronous active-low reset
//   btn_mode   in   mode button (synchronous, debounced level)
//   btn_inc    in   increment button (level)
//   btn_dec    in   decrement button (level)
//   dp         master modport of time_set_ctrl_if (cur digits in; load/select/loadin out)
//   editing    out  high while editing
//   blink      out  blink phase for the selected digit
//   done       out  one-cycle pulse on normal completion
//   timeout    out  one-cycle pulse on auto-exit
// All outputs are decoded from registers only; no input-to-output path.
module time_set_ctrl #(
  parameter int unsigned TIMEOUT = 30,
  parameter int unsigned BLINK   = 1
) (
  input  logic                  clk_out,
  input  logic                  rst_n,
  input  logic                  btn_mode,
  input  logic                  btn_inc,
  input  logic                  btn_dec,
  time_set_ctrl_if.master       dp,
  output logic                  editing,
  output logic                  blink,
  output logic                  done,
  output logic                  timeout
);

  localparam int unsigned DIG_W = 4;
  localparam int unsigned IDX_W = 3;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned BLK_W = 8;

  localparam logic [IDX_W-1:0] IDX_H1     = IDX_W'(5);
  localparam logic [IDX_W-1:0] IDX_H2     = IDX_W'(4);
  localparam logic [CNT_W-1:0] IDLE_LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [BLK_W-1:0] BLINK_LAST = BLK_W'(BLINK - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EDIT   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [DIG_W-1:0] val_q, val_d;
  logic [DIG_W-1:0] h1_q, h1_d;
  logic [CNT_W-1:0] idle_q, idle_d;
  logic [BLK_W-1:0] bcnt_q, bcnt_d;
  logic             blink_q, blink_d;
  logic             to_q, to_d;
  logic             mode_prev, inc_prev, dec_prev;

  logic             mode_ev, inc_ev, dec_ev;
  logic [IDX_W-1:0] idx_dn;
  logic [DIG_W-1:0] h1_eff;
  logic [DIG_W-1:0] max_cur, max_dn;
  logic [DIG_W-1:0] seed_raw, seed;

  // Largest legal BCD value for a digit position; h2 depends on the hours tens.
  function automatic logic [DIG_W-1:0] digit_max(input logic [IDX_W-1:0] i,
                                                 input logic [DIG_W-1:0] h1);
    logic [DIG_W-1:0] m;
    case (i)
      IDX_W'(0): m = DIG_W'(9);
      IDX_W'(1): m = DIG_W'(5);
      IDX_W'(2): m = DIG_W'(9);
      IDX_W'(3): m = DIG_W'(5);
      IDX_W'(4): m = (h1 == DIG_W'(2)) ? DIG_W'(3) : DIG_W'(9);
      IDX_W'(5): m = DIG_W'(2);
      default:   m = DIG_W'(9);
    endcase
    return m;
  endfunction

  // Rising-edge button events; a held button yields one event.
  assign mode_ev = btn_mode & ~mode_prev;
  assign inc_ev  = btn_inc  & ~inc_prev;
  assign dec_ev  = btn_dec  & ~dec_prev;

  // Seed for the next digit: h1 is being captured in the same cycle we leave
  // idx 5, so the h2 limit must use the live value rather than h1_q.
  assign idx_dn  = idx_q - IDX_W'(1);
  assign h1_eff  = (idx_q == IDX_H1) ? val_q : h1_q;
  assign max_cur = digit_max(idx_q, h1_q);
  assign max_dn  = digit_max(idx_dn, h1_eff);

  always_comb begin
    case (idx_dn)
      IDX_W'(4): seed_raw = dp.cur_h2;
      IDX_W'(3): seed_raw = dp.cur_m1;
      IDX_W'(2): seed_raw = dp.cur_m2;
      IDX_W'(1): seed_raw = dp.cur_s1;
      IDX_W'(0): seed_raw = dp.cur_s2;
      default:   seed_raw = dp.cur_h1;
    endcase
  end

  assign seed = (seed_raw > max_dn) ? DIG_W'(0) : seed_raw;

  // Button history registers.
  always_ff @(posedge clk_out or negedge rst_n) begin
    if (!rst_n) begin
      mode_prev <= 1'b0;
      inc_prev  <= 1'b0;
      dec_prev  <= 1'b0;
    end else begin
      mode_prev <= btn_mode;
      inc_prev  <= btn_inc;
      dec_prev  <= btn_dec;
    end
  end

  // FSM and datapath state register.
  always_ff @(posedge clk_out or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= IDX_H1;
      val_q   <= '0;
      h1_q    <= '0;
      idle_q  <= '0;
      bcnt_q  <= '0;
      blink_q <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      val_q   <= val_d;
      h1_q    <= h1_d;
      idle_q  <= idle_d;
      bcnt_q  <= bcnt_d;
      blink_q <= blink_d;
      to_q    <= to_d;
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    val_d      = val_q;
    h1_d       = h1_q;
    idle_d     = idle_q;
    bcnt_d     = '0;
    blink_d    = 1'b0;
    to_d       = 1'b0;
    dp.load    = 1'b0;
    dp.select  = IDX_H1;
    dp.loadin  = '0;
    editing    = 1'b0;
    blink      = 1'b0;
    done       = 1'b0;
    timeout    = to_q;

    case (state_q)
      IDLE: begin
        if (mode_ev) begin
          state_d = EDIT;
          idx_d   = IDX_H1;
          val_d   = dp.cur_h1;
          idle_d  = '0;
          blink_d = 1'b1;
        end
      end

      EDIT: begin
        dp.load   = 1'b1;
        dp.select = idx_q;
        dp.loadin = val_q;
        editing   = 1'b1;
        blink     = blink_q;

        if (mode_ev) begin
          // Mode wins; inc/dec seen in the same cycle are dropped.
          idle_d = '0;
          if (idx_q == IDX_W'(0)) begin
            state_d = COMMIT;
          end else begin
            if (idx_q == IDX_H1) h1_d = val_q;
            idx_d = idx_dn;
            val_d = seed;
          end
        end else if (inc_ev || dec_ev) begin
          idle_d = '0;
          if (inc_ev && !dec_ev) begin
            val_d = (val_q >= max_cur) ? DIG_W'(0) : val_q + DIG_W'(1);
          end else if (dec_ev && !inc_ev) begin
            val_d = (val_q == DIG_W'(0) || val_q > max_cur) ? max_cur : val_q - DIG_W'(1);
          end
        end else if (idle_q >= IDLE_LAST) begin
          state_d = IDLE;
          to_d    = 1'b1;
        end else begin
          // Bounded by IDLE_LAST above, so this never wraps.
          idle_d = idle_q + CNT_W'(1);
        end

        // Blink restarts lit whenever the shown digit or its value moves.
        if (state_d == EDIT) begin
          if (idx_d != idx_q || val_d != val_q) begin
            blink_d = 1'b1;
            bcnt_d  = '0;
          end else if (bcnt_q >= BLINK_LAST) begin
            blink_d = ~blink_q;
            bcnt_d  = '0;
          end else begin
            blink_d = blink_q;
            bcnt_d  = bcnt_q + BLK_W'(1);
          end
        end
      end

      COMMIT: begin
        done    = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_time_set_ctrl.sv
// Bench for time_set_ctrl: a cycle model of the editing rules checked on
// every falling edge, plus directed scenarios with literal expectations.
// A second instance with TIMEOUT=5 pins the auto-exit timing.
module tb_time_set_ctrl;

  localparam int TO = 12;
  localparam int BL = 2;

  logic clk;
  logic rst_n;
  logic b_mode, b_inc, b_dec;
  logic [3:0] cur [6];
  logic editing, blink, done, timeout;
  logic editing5, blink5, done5, timeout5;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 0;

  time_set_ctrl_if bus ();
  time_set_ctrl_if bus5 ();

  assign bus.cur_h1  = cur[5];
  assign bus.cur_h2  = cur[4];
  assign bus.cur_m1  = cur[3];
  assign bus.cur_m2  = cur[2];
  assign bus.cur_s1  = cur[1];
  assign bus.cur_s2  = cur[0];
  assign bus5.cur_h1 = cur[5];
  assign bus5.cur_h2 = cur[4];
  assign bus5.cur_m1 = cur[3];
  assign bus5.cur_m2 = cur[2];
  assign bus5.cur_s1 = cur[1];
  assign bus5.cur_s2 = cur[0];

  time_set_ctrl #(.TIMEOUT(TO), .BLINK(BL)) dut (
    .clk_out  (clk),
    .rst_n    (rst_n),
    .btn_mode (b_mode),
    .btn_inc  (b_inc),
    .btn_dec  (b_dec),
    .dp       (bus),
    .editing  (editing),
    .blink    (blink),
    .done     (done),
    .timeout  (timeout)
  );

  time_set_ctrl #(.TIMEOUT(5), .BLINK(1)) dut5 (
    .clk_out  (clk),
    .rst_n    (rst_n),
    .btn_mode (b_mode),
    .btn_inc  (b_inc),
    .btn_dec  (b_dec),
    .dp       (bus5),
    .editing  (editing5),
    .blink    (blink5),
    .done     (done5),
    .timeout  (timeout5)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_mode: 0 idle, 1 editing, 2 completion cycle. m_t counts cycles since
  // the blink last restarted; the lamp is lit during even BL-long slots.
  int m_mode = 0, m_idx = 5, m_val = 0, m_h1 = 0, m_idle = 0, m_t = 0;
  bit m_to = 0, pm = 0, pi = 0, pd = 0;
  bit em, ei, ed;
  int old_v, lim;

  function automatic int mx(input int i, input int h1);
    int r;
    case (i)
      0: r = 9;
      1: r = 5;
      2: r = 9;
      3: r = 5;
      4: r = (h1 == 2) ? 3 : 9;
      default: r = 2;
    endcase
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0; m_idx = 5; m_val = 0; m_h1 = 0; m_idle = 0; m_t = 0;
      m_to = 0; pm = 0; pi = 0; pd = 0;
    end else begin
      em = b_mode && !pm;
      ei = b_inc && !pi;
      ed = b_dec && !pd;
      pm = b_mode; pi = b_inc; pd = b_dec;
      m_to = 0;
      if (m_mode == 0) begin
        if (em) begin
          m_mode = 1; m_idx = 5; m_val = int'(cur[5]); m_idle = 0; m_t = 0;
        end
      end else if (m_mode == 2) begin
        m_mode = 0;
      end else begin
        lim = mx(m_idx, m_h1);
        if (em) begin
          m_idle = 0;
          if (m_idx == 0) m_mode = 2;
          else begin
            if (m_idx == 5) m_h1 = m_val;
            m_idx = m_idx - 1;
            m_val = (int'(cur[m_idx]) > mx(m_idx, m_h1)) ? 0 : int'(cur[m_idx]);
            m_t = 0;
          end
        end else if (ei || ed) begin
          m_idle = 0;
          old_v = m_val;
          if (ei && !ed) m_val = (m_val >= lim) ? 0 : m_val + 1;
          else if (ed && !ei) m_val = (m_val == 0 || m_val > lim) ? lim : m_val - 1;
          if (m_val != old_v) m_t = 0; else m_t++;
        end else if (m_idle == TO - 1) begin
          m_mode = 0; m_to = 1;
        end else begin
          m_idle++; m_t++;
        end
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_load",    int'(bus.load),   (m_mode == 1) ? 1 : 0);
      chk("model_editing", int'(editing),    (m_mode == 1) ? 1 : 0);
      chk("model_select",  int'(bus.select), (m_mode == 1) ? m_idx : 5);
      chk("model_loadin",  int'(bus.loadin), (m_mode == 1) ? m_val : 0);
      chk("model_blink",   int'(blink),      (m_mode == 1 && ((m_t / BL) % 2 == 0)) ? 1 : 0);
      chk("model_done",    int'(done),       (m_mode == 2) ? 1 : 0);
      chk("model_timeout", int'(timeout),    int'(m_to));
    end
  end

  // ---------------- stimulus ----------------
  // One press: a low cycle, then the buttons high across one rising edge.
  task automatic ev(input bit m, input bit i, input bit d);
    @(negedge clk);
    b_mode = m; b_inc = i; b_dec = d;
    @(negedge clk);
    b_mode = 0; b_inc = 0; b_dec = 0;
  endtask

  task automatic reset_outs(input string tag);
    chk({tag, "_load"},    int'(bus.load),   0);
    chk({tag, "_select"},  int'(bus.select), 5);
    chk({tag, "_loadin"},  int'(bus.loadin), 0);
    chk({tag, "_editing"}, int'(editing),    0);
    chk({tag, "_blink"},   int'(blink),      0);
    chk({tag, "_done"},    int'(done),       0);
    chk({tag, "_timeout"}, int'(timeout),    0);
  endtask

  int h2_seq [4] = '{1, 2, 3, 0};
  int cyc;
  bit to_seen;

  initial begin
    b_mode = 0; b_inc = 0; b_dec = 0;
    cur[5] = 4'd1; cur[4] = 4'd2; cur[3] = 4'd3;
    cur[2] = 4'd4; cur[1] = 4'd5; cur[0] = 4'd6;
    rst_n = 1'b1;
    #3 rst_n = 1'b0;
    #1 reset_outs("por");
    chk_en = 1;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;

    // Full set from 12:34:56 to 23:59:59.
    ev(1, 0, 0);
    chk("set_enter_sel", int'(bus.select), 5);
    chk("set_enter_val", int'(bus.loadin), 1);
    chk("set_enter_blink", int'(blink), 1);
    ev(0, 1, 0);
    chk("set_h1_2", int'(bus.loadin), 2);
    ev(1, 0, 0);
    chk("set_h2_sel", int'(bus.select), 4);
    chk("set_h2_seed", int'(bus.loadin), 2);
    ev(0, 1, 0);
    chk("set_h2_3", int'(bus.loadin), 3);
    ev(1, 0, 0);
    chk("set_m1_seed", int'(bus.loadin), 3);
    ev(0, 1, 0);
    ev(0, 1, 0);
    chk("set_m1_5", int'(bus.loadin), 5);
    ev(1, 0, 0);
    chk("set_m2_sel", int'(bus.select), 2);
    chk("set_m2_seed", int'(bus.loadin), 4);
    repeat (5) ev(0, 0, 1);
    chk("set_m2_decwrap_9", int'(bus.loadin), 9);
    ev(1, 0, 0);
    chk("set_s1_seed", int'(bus.loadin), 5);
    ev(1, 0, 0);
    chk("set_s2_sel", int'(bus.select), 0);
    chk("set_s2_seed", int'(bus.loadin), 6);
    repeat (3) ev(0, 1, 0);
    chk("set_s2_9", int'(bus.loadin), 9);
    ev(1, 0, 0);
    chk("commit_done", int'(done), 1);
    chk("commit_load", int'(bus.load), 0);
    chk("commit_timeout", int'(timeout), 0);
    @(negedge clk);
    chk("after_commit_done", int'(done), 0);

    // Hour clamp: h1=2 with cur_h2=7 seeds h2 as 0; h2 wraps at 3.
    cur[4] = 4'd7;
    ev(1, 0, 0);
    ev(0, 1, 0);
    ev(1, 0, 0);
    chk("clamp_h2_seed", int'(bus.loadin), 0);
    for (int k = 0; k < 4; k++) begin
      ev(0, 1, 0);
      chk("clamp_h2_inc", int'(bus.loadin), h2_seq[k]);
    end
    ev(0, 0, 1);
    chk("clamp_h2_dec0", int'(bus.loadin), 3);

    // Priority: mode beats inc/dec; inc+dec alone is a no-op.
    ev(1, 1, 1);
    chk("prio_sel", int'(bus.select), 3);
    chk("prio_seed", int'(bus.loadin), 3);
    ev(0, 1, 1);
    chk("incdec_nochange", int'(bus.loadin), 3);
    ev(0, 1, 0);
    chk("incdec_then_inc", int'(bus.loadin), 4);
    repeat (TO + 4) @(negedge clk);
    chk("auto_exit_editing", int'(editing), 0);

    // Short-timeout instance: five editing cycles, then a single pulse.
    ev(1, 0, 0);
    cyc = 1;
    to_seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("t5_done_low", int'(done5), 0);
      if (editing5) cyc++;
      else begin
        to_seen = timeout5;
        break;
      end
    end
    chk("t5_edit_cycles", cyc, 5);
    chk("t5_timeout_pulse", int'(to_seen), 1);
    @(negedge clk);
    chk("t5_timeout_gone", int'(timeout5), 0);
    repeat (TO + 4) @(negedge clk);

    // Held increment: one step only.
    ev(1, 0, 0);
    @(negedge clk);
    b_inc = 1;
    repeat (10) @(negedge clk);
    b_inc = 0;
    chk("held_inc_val", int'(bus.loadin), 2);
    chk("held_inc_editing", int'(editing), 1);
    repeat (TO + 4) @(negedge clk);

    // Reset in the middle of an edit at idx 2, mode held through release.
    ev(1, 0, 0);
    ev(1, 0, 0);
    ev(1, 0, 0);
    ev(1, 0, 0);
    chk("rst_pre_sel", int'(bus.select), 2);
    @(negedge clk);
    b_mode = 1;
    #2 rst_n = 1'b0;
    #1 reset_outs("midrst");
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("rel_editing", int'(editing), 1);
    chk("rel_sel", int'(bus.select), 5);
    repeat (3) @(negedge clk);
    chk("rel_held_sel", int'(bus.select), 5);
    b_mode = 0;
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
